// File: rtl/regfile_dbg_pkg.sv
// Shared types and constants for the register-file dump/load engine.
// Holds the FSM state encoding, operation mode codes and default widths.
package regfile_dbg_pkg;

  localparam int DEF_ADDRESS_WIDTH = 5;
  localparam int DEF_DATA_WIDTH    = 32;

  localparam logic MODE_DUMP = 1'b0;
  localparam logic MODE_LOAD = 1'b1;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DUMP_FETCH = 3'd1,
    DUMP_SEND  = 3'd2,
    LOAD       = 3'd3,
    DONE       = 3'd4
  } state_e;

endpackage

// File: rtl/regfile_dumper.sv
// Streams the whole register file out (DUMP) or fills x1..x(N-1) from an input
// stream (LOAD); a single counter walks the address space and never wraps.
module regfile_dumper
  import regfile_dbg_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n_i,
  input  logic                     start_i,
  input  logic                     mode_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [ADDRESS_WIDTH-1:0] rf_rd_addr_o,
  input  logic [DATA_WIDTH-1:0]    rf_rd_data_i,
  output logic [ADDRESS_WIDTH-1:0] rf_wr_addr_o,
  output logic                     rf_we_o,
  output logic [DATA_WIDTH-1:0]    rf_wd_o,
  output logic                     dout_valid_o,
  input  logic                     dout_ready_i,
  output logic [DATA_WIDTH-1:0]    dout_data_o,
  output logic [ADDRESS_WIDTH-1:0] dout_addr_o,
  input  logic                     din_valid_i,
  output logic                     din_ready_o,
  input  logic [DATA_WIDTH-1:0]    din_data_i,
  output state_e                   dbg_state_o
);

  // Streams: a word moves on any cycle where valid and ready are both high at
  // the rising edge; the producer holds data/address stable until then.

  localparam logic [ADDRESS_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [ADDRESS_WIDTH-1:0] CNT_ONE = ADDRESS_WIDTH'(1);

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] counter_q;
  logic                     dout_valid_q;
  logic [DATA_WIDTH-1:0]    dout_data_q;
  logic [ADDRESS_WIDTH-1:0] dout_addr_q;
  logic                     done_q;

  logic in_dump;
  logic in_load;

  always_ff @(posedge clk) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      dout_addr_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (mode_i == MODE_LOAD) begin
              state_q   <= LOAD;
              counter_q <= CNT_ONE;
            end else begin
              state_q   <= DUMP_FETCH;
              counter_q <= '0;
            end
          end
        end
        DUMP_FETCH: begin
          // x0 storage is never initialised, so its content is meaningless.
          dout_data_q  <= (counter_q == '0) ? '0 : rf_rd_data_i;
          dout_addr_q  <= counter_q;
          dout_valid_q <= 1'b1;
          state_q      <= DUMP_SEND;
        end
        DUMP_SEND: begin
          if (dout_ready_i) begin
            dout_valid_q <= 1'b0;
            if (counter_q == CNT_MAX) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              counter_q <= counter_q + CNT_ONE;
              state_q   <= DUMP_FETCH;
            end
          end
        end
        LOAD: begin
          if (din_valid_i) begin
            if (counter_q == CNT_MAX) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              counter_q <= counter_q + CNT_ONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_dump = (state_q == DUMP_FETCH) || (state_q == DUMP_SEND);
  assign in_load = (state_q == LOAD);

  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign rf_rd_addr_o = in_dump ? counter_q : '0;
  assign rf_wr_addr_o = in_load ? counter_q : '0;
  assign rf_we_o      = in_load & din_valid_i;
  assign rf_wd_o      = din_data_i;
  assign din_ready_o  = in_load;
  assign dout_valid_o = dout_valid_q;
  assign dout_data_o  = dout_data_q;
  assign dout_addr_o  = dout_addr_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed bench for regfile_dumper: a behavioural 32x32 register file sits on
// the read/write ports, inputs change on the falling edge, outputs are sampled there.
module tb_regfile_dumper;
  import regfile_dbg_pkg::*;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n_i;
  logic          start_i;
  logic          mode_i;
  logic          busy_o;
  logic          done_o;
  logic [AW-1:0] rf_rd_addr_o;
  logic [DW-1:0] rf_rd_data_i;
  logic [AW-1:0] rf_wr_addr_o;
  logic          rf_we_o;
  logic [DW-1:0] rf_wd_o;
  logic          dout_valid_o;
  logic          dout_ready_i;
  logic [DW-1:0] dout_data_o;
  logic [AW-1:0] dout_addr_o;
  logic          din_valid_i;
  logic          din_ready_o;
  logic [DW-1:0] din_data_i;
  state_e        dbg_state_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rf [0:31];
  logic          rf_init;
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  logic [AW-1:0] got_addr_q [$];
  logic [DW-1:0] got_data_q [$];

  regfile_dumper #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .rf_rd_addr_o (rf_rd_addr_o),
    .rf_rd_data_i (rf_rd_data_i),
    .rf_wr_addr_o (rf_wr_addr_o),
    .rf_we_o      (rf_we_o),
    .rf_wd_o      (rf_wd_o),
    .dout_valid_o (dout_valid_o),
    .dout_ready_i (dout_ready_i),
    .dout_data_o  (dout_data_o),
    .dout_addr_o  (dout_addr_o),
    .din_valid_i  (din_valid_i),
    .din_ready_o  (din_ready_o),
    .din_data_i   (din_data_i),
    .dbg_state_o  (dbg_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: x0 holds junk so the forced-zero capture is visible.
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hDEAD_0000 | i;
    end else if (rf_we_o) begin
      rf[rf_wr_addr_o] <= rf_wd_o;
      wr_addr_q.push_back(rf_wr_addr_o);
      wr_data_q.push_back(rf_wd_o);
    end
  end

  assign rf_rd_data_i = rf[rf_rd_addr_o];

  function automatic logic [DW-1:0] exp_word(input int a);
    return (a == 0) ? 32'h0 : (32'h100 + a);
  endfunction

  // Runs one dump with ready held high; returns first done cycle, done count
  // and the cycle busy dropped, all counted in edges after the start edge.
  task automatic do_dump(output int done_cyc, output int n_done, output int exit_cyc);
    int n;
    got_addr_q.delete();
    got_data_q.delete();
    @(negedge clk);
    start_i = 1'b1; mode_i = MODE_DUMP; dout_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0; done_cyc = -1; n_done = 0;
    while (busy_o && n < 300) begin
      if (dout_valid_o && dout_ready_i) begin
        got_addr_q.push_back(dout_addr_o);
        got_data_q.push_back(dout_data_o);
      end
      if (done_o) begin
        n_done++;
        if (done_cyc < 0) done_cyc = n;
      end
      @(negedge clk);
      n++;
    end
    exit_cyc = n;
  endtask

  task automatic test_reset;
    rst_n_i = 1'b0; rf_init = 1'b1; start_i = 1'b1; mode_i = MODE_DUMP;
    dout_ready_i = 1'b0; din_valid_i = 1'b0; din_data_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || dbg_state_o !== IDLE) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b state=%0d, required busy=0 done=0 state=0",
               busy_o, done_o, dbg_state_o);
    end
    checks++;
    if (dout_valid_o !== 1'b0 || dout_data_o !== 32'h0 || dout_addr_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_dout: valid=%b data=%h addr=%0d, required 0/0/0",
               dout_valid_o, dout_data_o, dout_addr_o);
    end
    checks++;
    if (rf_we_o !== 1'b0 || din_ready_o !== 1'b0 || rf_rd_addr_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_rf_ports: we=%b din_ready=%b rd_addr=%0d, required 0/0/0",
               rf_we_o, din_ready_o, rf_rd_addr_o);
    end
    start_i = 1'b0; rf_init = 1'b0; rst_n_i = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_after: busy=%b, required 0", busy_o);
    end
  endtask

  task automatic test_load_gaps;
    int n, idx, n_done;
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    start_i = 1'b1; mode_i = MODE_LOAD;
    @(negedge clk);
    start_i = 1'b0;
    n = 0; idx = 1; n_done = 0;
    while (busy_o && n < 400) begin
      // Pulse start with dump mode mid-load: must not restart or move the counter.
      start_i = (n == 10);
      mode_i  = (n == 10) ? MODE_DUMP : MODE_LOAD;
      if (din_ready_o && idx <= 31 && (n % 3) != 2) begin
        din_valid_i = 1'b1;
        din_data_i  = 32'h100 + idx;
        idx++;
      end else begin
        din_valid_i = 1'b0;
        din_data_i  = 32'hBAD0_0000;
      end
      if (done_o) begin
        n_done++;
        start_i = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    start_i = 1'b0; din_valid_i = 1'b0;
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL load_done_count: got %0d pulses, required 1", n_done);
    end
    checks++;
    if (wr_addr_q.size() !== 31) begin
      errors++;
      $display("FAIL load_write_count: got %0d writes, required 31", wr_addr_q.size());
    end
    for (int k = 0; k < wr_addr_q.size() && k < 31; k++) begin
      checks++;
      if (wr_addr_q[k] !== 5'(k + 1) || wr_data_q[k] !== 32'h100 + k + 1) begin
        errors++;
        $display("FAIL load_write_%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 k, wr_addr_q[k], wr_data_q[k], k + 1, 32'h100 + k + 1);
      end
    end
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || dbg_state_o !== IDLE) begin
      errors++;
      $display("FAIL start_in_done_ignored: busy=%b state=%0d, required busy=0 state=0",
               busy_o, dbg_state_o);
    end
  endtask

  task automatic test_dump_full;
    int dc, nd, ec;
    do_dump(dc, nd, ec);
    checks++;
    if (dc !== 64) begin
      errors++;
      $display("FAIL dump_done_cycle: got %0d, required 64", dc);
    end
    checks++;
    if (nd !== 1 || ec !== 65) begin
      errors++;
      $display("FAIL dump_done_busy: pulses=%0d busy_fall=%0d, required 1 and 65", nd, ec);
    end
    checks++;
    if (got_addr_q.size() !== 32) begin
      errors++;
      $display("FAIL dump_word_count: got %0d, required 32", got_addr_q.size());
    end
    for (int k = 0; k < got_addr_q.size() && k < 32; k++) begin
      checks++;
      if (got_addr_q[k] !== 5'(k) || got_data_q[k] !== exp_word(k)) begin
        errors++;
        $display("FAIL dump_word_%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 k, got_addr_q[k], got_data_q[k], k, exp_word(k));
      end
    end
  endtask

  task automatic test_backpressure;
    int n, stall, nd;
    logic [DW-1:0] held;
    got_addr_q.delete();
    got_data_q.delete();
    @(negedge clk);
    start_i = 1'b1; mode_i = MODE_DUMP; dout_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0; stall = 0; nd = 0; held = '0;
    while (busy_o && n < 400) begin
      if (done_o) nd++;
      if (dout_valid_o && dout_addr_o == 5'd7 && stall < 5) begin
        if (stall > 0) begin
          checks++;
          if (dout_valid_o !== 1'b1 || dout_data_o !== held || dout_addr_o !== 5'd7) begin
            errors++;
            $display("FAIL stall_stable_%0d: valid=%b data=%h addr=%0d, required 1/%h/7",
                     stall, dout_valid_o, dout_data_o, dout_addr_o, held);
          end
        end
        held = dout_data_o;
        stall++;
        dout_ready_i = 1'b0;
      end else begin
        dout_ready_i = 1'b1;
      end
      if (dout_valid_o && dout_ready_i) begin
        got_addr_q.push_back(dout_addr_o);
        got_data_q.push_back(dout_data_o);
      end
      @(negedge clk);
      n++;
    end
    dout_ready_i = 1'b1;
    checks++;
    if (stall !== 5 || held !== 32'h107) begin
      errors++;
      $display("FAIL stall_word7: stalls=%0d data=%h, required 5 and 00000107", stall, held);
    end
    checks++;
    if (nd !== 1 || got_addr_q.size() !== 32) begin
      errors++;
      $display("FAIL stall_totals: done=%0d words=%0d, required 1 and 32", nd, got_addr_q.size());
    end
    for (int k = 0; k < got_addr_q.size() && k < 32; k++) begin
      checks++;
      if (got_addr_q[k] !== 5'(k) || got_data_q[k] !== exp_word(k)) begin
        errors++;
        $display("FAIL stall_word_%0d: addr=%0d data=%h, required addr=%0d data=%h",
                 k, got_addr_q[k], got_data_q[k], k, exp_word(k));
      end
    end
  endtask

  task automatic test_reset_mid_dump;
    int n, nd, dc, ec;
    @(negedge clk);
    start_i = 1'b1; mode_i = MODE_DUMP; dout_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    n = 0; nd = 0;
    while (!(dout_valid_o && dout_addr_o == 5'd12) && n < 100) begin
      if (done_o) nd++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (dbg_state_o !== DUMP_SEND || dout_addr_o !== 5'd12) begin
      errors++;
      $display("FAIL abort_reach_word12: state=%0d addr=%0d, required state=2 addr=12",
               dbg_state_o, dout_addr_o);
    end
    // Handshake offered in the same cycle as reset: reset must win.
    rst_n_i = 1'b0; start_i = 1'b1;
    @(negedge clk);
    rst_n_i = 1'b1; start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || dout_valid_o !== 1'b0 || done_o !== 1'b0 || rf_rd_addr_o !== 5'd0) begin
      errors++;
      $display("FAIL abort_state: busy=%b valid=%b done=%b rd_addr=%0d, required 0/0/0/0",
               busy_o, dout_valid_o, done_o, rf_rd_addr_o);
    end
    repeat (3) begin
      if (done_o) nd++;
      @(negedge clk);
    end
    checks++;
    if (nd !== 0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done: done=%0d busy=%b, required 0 and 0", nd, busy_o);
    end
    do_dump(dc, nd, ec);
    checks++;
    if (got_addr_q.size() !== 32 || nd !== 1 || dc !== 64) begin
      errors++;
      $display("FAIL restart_totals: words=%0d done=%0d cyc=%0d, required 32/1/64",
               got_addr_q.size(), nd, dc);
    end
    checks++;
    if (got_addr_q.size() < 13 || got_addr_q[0] !== 5'd0 || got_data_q[0] !== 32'h0 ||
        got_addr_q[12] !== 5'd12 || got_data_q[12] !== 32'h10C) begin
      errors++;
      $display("FAIL restart_from_zero: first addr=%0d data=%h, required addr=0 data=0",
               (got_addr_q.size() > 0) ? got_addr_q[0] : 5'd31,
               (got_data_q.size() > 0) ? got_data_q[0] : 32'hFFFF_FFFF);
    end
  endtask

  initial begin
    rst_n_i = 1'b0; rf_init = 1'b1; start_i = 1'b0; mode_i = MODE_DUMP;
    dout_ready_i = 1'b0; din_valid_i = 1'b0; din_data_i = '0;
    test_reset();
    test_load_gaps();
    test_dump_full();
    test_backpressure();
    test_reset_mid_dump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dumper.md
REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 5, register-file address width.
REQ-002 Parameter DATA_WIDTH, default 32, register data width.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst_n_i  in  1  reset; synchronous, active-low.
REQ-005 start_i  in  1  starts an operation; sampled only in IDLE.
REQ-006 mode_i  in  1  operation select, sampled with start_i: 0 = DUMP, 1 = LOAD.
REQ-007 busy_o  out  1  high in every state except IDLE.
REQ-008 done_o  out  1  one-cycle pulse when an operation completes.
REQ-009 rf_rd_addr_o  out  ADDRESS_WIDTH  drives register-file read port 1 address.
REQ-010 rf_rd_data_i  in  DATA_WIDTH  register-file read port 1 data, combinational from rf_rd_addr_o.
REQ-011 rf_wr_addr_o / rf_we_o / rf_wd_o  out  ADDRESS_WIDTH / 1 / DATA_WIDTH  drive register-file write port 3.
REQ-012 dout_valid_o / dout_ready_i / dout_data_o / dout_addr_o  out / in / out / out  1 / 1 / DATA_WIDTH / ADDRESS_WIDTH  dump output stream.
REQ-013 din_valid_i / din_ready_o / din_data_i  in / out / in  1 / 1 / DATA_WIDTH  load input stream.

Function
REQ-014 The FSM SHALL have the states IDLE, DUMP_FETCH, DUMP_SEND, LOAD and DONE.
REQ-015 IDLE with start_i=1: mode 0 -> DUMP_FETCH with counter=0; mode 1 -> LOAD with counter=1.
REQ-016 DUMP_FETCH: rf_rd_addr_o=counter; at the edge, capture data into dout_data_o and counter into dout_addr_o, set dout_valid_o=1, go to DUMP_SEND.
REQ-017 The captured data SHALL be forced to 0 when counter=0, because x0 storage is never initialised.
REQ-018 DUMP_SEND: dout_valid_o, dout_data_o and dout_addr_o SHALL stay stable until dout_ready_i=1.
REQ-019 DUMP_SEND handshake: clear dout_valid_o; if counter=2**ADDRESS_WIDTH-1 go to DONE, else increment counter and go to DUMP_FETCH.
REQ-020 Dump throughput is one word per 2 cycles when dout_ready_i is held high; a full dump is 64 cycles from start to DONE.
REQ-021 LOAD: din_ready_o=1, rf_we_o=din_valid_i, rf_wr_addr_o=counter, rf_wd_o=din_data_i, all combinational.
REQ-022 LOAD handshake: increment counter; if counter=2**ADDRESS_WIDTH-1 go to DONE; address 0 is never written.
REQ-023 Outside LOAD, rf_we_o=0 and din_ready_o=0.
REQ-024 DONE: done_o=1 for exactly one cycle, then return to IDLE.
REQ-025 start_i SHALL be ignored in every state except IDLE, including DONE.
REQ-026 The counter is ADDRESS_WIDTH bits wide and SHALL never wrap; termination is detected on the all-ones value before incrementing.
REQ-027 Outside the dump states, rf_rd_addr_o=0 and dout_valid_o=0.

Reset
REQ-028 rst_n_i=0 at a clock edge: state=IDLE, counter=0, dout_valid_o=0, dout_data_o=0, dout_addr_o=0, done_o=0.
REQ-029 Reset mid-operation SHALL abort without completion: no done_o, and rf_we_o=0 from the first cycle after the reset edge.
REQ-030 Reset has priority over start_i and over any handshake in the same cycle.

Structure
REQ-031 Package regfile_dbg_pkg SHALL hold the state enum, the mode constants (MODE_DUMP=0, MODE_LOAD=1) and the default widths.
REQ-032 The block is a single module (FSM, counter, output register) with no sub-module.
REQ-033 When used with the register file, the register-file read port 1 address is muxed to rf_rd_addr_o only while busy_o=1; that mux lives in the integration, not in this block.

Verification
REQ-034 Load then dump: load values 0x100+i to x1..x31, then dump -> 32 words; addr 0 data 0, addr i data 0x100+i; done_o pulses once per operation.
REQ-035 Backpressure: hold dout_ready_i=0 for 5 cycles on word 7 -> dout_data_o/dout_addr_o remain stable and valid stays high; no word is skipped.
REQ-036 Dump with dout_ready_i always 1 -> done_o at cycle 64 after start_i; busy_o falls the cycle after done_o.
REQ-037 LOAD with din_valid_i gaps -> rf_we_o only on valid cycles, writes reach x1..x31 in order, x0 never written.
REQ-038 Assert rst_n_i=0 during DUMP_SEND of word 12 -> IDLE next cycle, dout_valid_o=0, no done_o; a new start_i then dumps from addr 0.
REQ-039 Pulse start_i during DONE and during LOAD -> ignored; no restart and counter unaffected.
